packet_read_arbiter: RTL

PACKET_READ_ARBITER -- requirements
Module: packet_read_arbiter

---
 rtl/packet_read_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/packet_read_arbiter.sv
// packet_read_arbiter: streams whole packets from pPORTS packet buffers onto a
// single Avalon-ST source. A port is picked round-robin, its length-FIFO entry
// is popped, and its bytes are read through a 2-entry skid buffer at up to one
// beat per cycle.
// Optional feature: define ARB_STRICT_PORT0_EN to give port 0 strict priority
// over the round-robin among the remaining ports.

module packet_read_arbiter #(
  parameter int pPORTS             = 4,
  parameter int pDATA_WIDTH        = 8,
  parameter int pMAX_PACKET_LENGHT = 1536,
  localparam int pLEN_WIDTH        = $clog2(pMAX_PACKET_LENGHT) + 1,
  localparam int pCH_WIDTH         = (pPORTS > 1) ? $clog2(pPORTS) : 1
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic [pPORTS-1:0]             iempty_fifo,
  input  logic [pPORTS*pLEN_WIDTH-1:0]  ilen,
  input  logic [pPORTS*pDATA_WIDTH-1:0] ird_data,
  output logic [pPORTS-1:0]             olen_pop,
  output logic [pPORTS-1:0]             odata_rd,
  input  logic                          iready,
  output logic                          ovalid,
  output logic [pDATA_WIDTH-1:0]        odata,
  output logic                          ostartofpacket,
  output logic                          oendofpacket,
  output logic [pCH_WIDTH-1:0]          ochannel,
  output logic                          obusy
);

  localparam logic [pLEN_WIDTH-1:0] LEN_MAX = pLEN_WIDTH'(pMAX_PACKET_LENGHT);
  localparam logic [pLEN_WIDTH-1:0] LEN_ONE = pLEN_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [pCH_WIDTH-1:0]   grant, last_grant, sel, cand;
  logic                   found;
  logic [pLEN_WIDTH-1:0]  remaining, remaining_nxt, len_g, len_clamped;
  logic                   rd_en, strobe_sop, strobe_eop, last_load;
  logic                   inflight, inflight_sop, inflight_eop;
  logic [pDATA_WIDTH-1:0] sk_data [2];
  logic [1:0]             sk_sop, sk_eop;
  logic                   wr_ptr, rd_ptr, push, pop;
  logic [1:0]             count;
  logic [2:0]             occ_next;

  // Arbitration: first non-empty port searching upward from last_grant+1.
  // NOTE: every variable driven here gets a default before any branch, so no latch can be inferred.
  always_comb begin
    sel   = last_grant;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= pPORTS; i++) begin
      cand = pCH_WIDTH'((int'(last_grant) + i) % pPORTS);
`ifdef ARB_STRICT_PORT0_EN
      if (!found && !iempty_fifo[cand] && cand != '0) begin
`else
      if (!found && !iempty_fifo[cand]) begin
`endif
        found = 1'b1;
        sel   = cand;
      end
    end
`ifdef ARB_STRICT_PORT0_EN
    if (!iempty_fifo[0]) begin
      found = 1'b1;
      sel   = '0;
    end
`endif
  end

  assign len_g       = ilen[grant*pLEN_WIDTH +: pLEN_WIDTH];
  assign len_clamped = (len_g > LEN_MAX) ? LEN_MAX : len_g;
  assign ovalid      = (count != 2'd0);
  assign pop         = ovalid & iready;
  assign push        = inflight;
  // Occupancy the buffer will have once this cycle's pop and capture settle;
  // a new strobe is safe when that leaves room for its byte next cycle.
  assign occ_next    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  // Next-state, length-FIFO pop and byte-read strobes.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    rd_en         = 1'b0;
    last_load     = 1'b0;
    olen_pop      = '0;
    odata_rd      = '0;
    case (state)
      IDLE: if (found) state_nxt = GRANT;
      GRANT: begin
        olen_pop[grant] = 1'b1;
        if (len_g == '0) begin
          state_nxt = IDLE;
          last_load = 1'b1;
        end else begin
          // The buffer is always empty here, so the first byte is read in the
          // same cycle the length is taken; this keeps the inter-packet gap short.
          rd_en         = 1'b1;
          remaining_nxt = len_clamped - LEN_ONE;
          state_nxt     = XFER;
        end
      end
      XFER: begin
        rd_en = (remaining != '0) && (occ_next < 3'd2);
        if (rd_en) remaining_nxt = remaining - LEN_ONE;
        if (remaining_nxt == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && oendofpacket) begin
          state_nxt = IDLE;
          last_load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    odata_rd[grant] = rd_en;
  end

  assign strobe_sop = rd_en && (state == GRANT);
  assign strobe_eop = rd_en && (remaining_nxt == '0);

  // Control state: FSM, grant bookkeeping, read-in-flight tracking, buffer pointers.
  // NOTE: reset is synchronous and all state updates are non-blocking, so every register samples pre-edge values.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= pCH_WIDTH'(pPORTS - 1);
      remaining    <= '0;
      inflight     <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      state        <= state_nxt;
      remaining    <= remaining_nxt;
      if (state == IDLE && found) grant <= sel;
      if (last_load) last_grant <= grant;
      inflight     <= rd_en;
      inflight_sop <= strobe_sop;
      inflight_eop <= strobe_eop;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count        <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Skid buffer storage: capture the byte returned one cycle after its strobe.
  // NOTE: the entries carry no reset; every output that reads them is qualified by ovalid, which comes from the reset count.
  always_ff @(posedge iclk) begin
    if (push) begin
      sk_data[wr_ptr] <= ird_data[grant*pDATA_WIDTH +: pDATA_WIDTH];
      sk_sop[wr_ptr]  <= inflight_sop;
      sk_eop[wr_ptr]  <= inflight_eop;
    end
  end

  assign odata          = ovalid ? sk_data[rd_ptr] : '0;
  assign ostartofpacket = ovalid & sk_sop[rd_ptr];
  assign oendofpacket   = ovalid & sk_eop[rd_ptr];
  assign ochannel       = ovalid ? grant : '0;
  assign obusy          = (state != IDLE);

endmodule
